// File: rtl/pulse_train_checker_if.sv
// Pulse train checker bundle: arm/line inputs and measurement results.
interface pulse_train_checker_if #(
   parameter int MaxPulses = 15
);
   localparam int CntW = $clog2(2 * MaxPulses + 2);

   logic            arm;
   logic            pulse_i;
   logic            busy;
   logic            done;
   logic [CntW-1:0] pulse_cnt;
   logic [CntW-1:0] edge_cnt;
   logic            end_level;
   logic            err_idle;
   logic            err_width;
   logic            err_ovf;

   modport master (
      output arm, pulse_i,
      input  busy, done, pulse_cnt, edge_cnt,
      input  end_level, err_idle, err_width, err_ovf
   );

   modport slave (
      input  arm, pulse_i,
      output busy, done, pulse_cnt, edge_cnt,
      output end_level, err_idle, err_width, err_ovf
   );
endinterface

// File: rtl/pulse_train_checker.sv
// Measures a pulse train: edge/pulse counts, half-width tolerance, idle/end level.
// PULSE_TRAIN_CHECKER_SYNC_EN adds a 2-flop input synchronizer on pulse_i.
module pulse_train_checker #(
   parameter int   ClockPeriod   = 50,
   parameter int   PulseWidth    = 100,
   parameter int   TolCycles     = 1,
   parameter logic IdlePolarity  = 1'b0,
   parameter int   MaxPulses     = 15,
   parameter int   TimeoutCycles = 8
) (
   input logic                  clk,
   input logic                  reset_n,
   pulse_train_checker_if.slave bus
);
   localparam int W        = PulseWidth / ClockPeriod + 1;
   localparam int Limit    = W + TimeoutCycles;
   localparam int WcW      = $clog2(Limit + 1);
   localparam int CntW     = $clog2(2 * MaxPulses + 2);
   localparam int MaxEdges = 2 * MaxPulses + 1;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      MEASURE,
      DONE
   } state_t;

   state_t          state, n_state;
   logic            line;
   logic            prev_level;
   logic            edge_seen;
   logic [WcW-1:0]  width_cnt, n_width;
   logic [CntW-1:0] edge_cnt, n_edge;
   logic [CntW-1:0] pulse_cnt, n_pulse;
   logic            end_level, n_end;
   logic            err_idle, n_eidle;
   logic            err_width, n_ewidth;
   logic            err_ovf, n_eovf;
   logic            busy, done;
   logic            start, finish, bad_width;

`ifdef PULSE_TRAIN_CHECKER_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= {2{IdlePolarity}};
      else          sync <= {sync[0], bus.pulse_i};
   end

   assign line = sync[1];
`else
   assign line = bus.pulse_i;
`endif

   assign edge_seen = line ^ prev_level;

   assign bad_width =
      (int'(width_cnt) < W - TolCycles) ||
      (int'(width_cnt) > W + TolCycles);

   always_comb begin
      n_state  = state;
      n_width  = width_cnt;
      n_edge   = edge_cnt;
      n_pulse  = pulse_cnt;
      n_end    = end_level;
      n_eidle  = err_idle;
      n_ewidth = err_width;
      n_eovf   = err_ovf;
      start    = 1'b0;
      finish   = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.arm) start = 1'b1;
         end
         ARMED: begin
            if (!bus.arm) begin
               n_state = IDLE;
            end else if (edge_seen) begin
               n_state = MEASURE;
               n_edge  = CntW'(1);
               n_width = WcW'(1);
            end
         end
         MEASURE: begin
            // abort beats edge, edge beats timeout
            if (!bus.arm) begin
               n_state = IDLE;
            end else if (edge_seen) begin
               if (edge_cnt == CntW'(MaxEdges)) begin
                  n_eovf = 1'b1;
                  finish = 1'b1;
               end else begin
                  if (bad_width) n_ewidth = 1'b1;
                  n_edge  = edge_cnt + CntW'(1);
                  n_width = WcW'(1);
               end
            end else if (width_cnt == WcW'(Limit)) begin
               finish = 1'b1;
            end else begin
               n_width = width_cnt + WcW'(1);
            end
         end
         DONE: begin
            if (bus.arm) start = 1'b1;
            else         n_state = IDLE;
         end
      endcase

      if (start) begin
         n_state  = ARMED;
         n_edge   = '0;
         n_pulse  = '0;
         n_end    = 1'b0;
         n_ewidth = 1'b0;
         n_eovf   = 1'b0;
         n_eidle  = (line != IdlePolarity);
      end

      if (finish) begin
         n_state = DONE;
         n_end   = line;
         n_pulse = edge_cnt >> 1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         prev_level <= IdlePolarity;
         width_cnt  <= '0;
         edge_cnt   <= '0;
         pulse_cnt  <= '0;
         end_level  <= 1'b0;
         err_idle   <= 1'b0;
         err_width  <= 1'b0;
         err_ovf    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= n_state;
         prev_level <= line;
         width_cnt  <= n_width;
         edge_cnt   <= n_edge;
         pulse_cnt  <= n_pulse;
         end_level  <= n_end;
         err_idle   <= n_eidle;
         err_width  <= n_ewidth;
         err_ovf    <= n_eovf;
         busy       <= (n_state == ARMED) || (n_state == MEASURE);
         done       <= (n_state == DONE);
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.pulse_cnt = pulse_cnt;
   assign bus.edge_cnt  = edge_cnt;
   assign bus.end_level = end_level;
   assign bus.err_idle  = err_idle;
   assign bus.err_width = err_width;
   assign bus.err_ovf   = err_ovf;
endmodule
